// File: rtl/pwm_dac.sv
// PWM audio DAC: buffers N-bit samples in a D-deep FIFO and plays one sample per 2^N-clock PWM period.
// Optional macro PWM_DAC_SIGNED_EN takes two's-complement samples, stored offset by 2^(N-1) so 0 idles at 50%.
module pwm_dac #(
    parameter int N = 10,
    parameter int D = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic [N-1:0]       in_sample,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               underrun_clr,
    output logic               pwm_out,
    output logic               period_strobe,
    output logic [$clog2(D):0] level,
    output logic               underrun
);

    localparam int AW = $clog2(D);
    localparam int LW = AW + 1;

`ifdef PWM_DAC_SIGNED_EN
    localparam logic [N-1:0] DUTY_RST = {1'b1, {(N-1){1'b0}}};
`else
    localparam logic [N-1:0] DUTY_RST = '0;
`endif

    function automatic logic [N-1:0] to_duty(input logic [N-1:0] s);
`ifdef PWM_DAC_SIGNED_EN
        return {~s[N-1], s[N-2:0]};
`else
        return s;
`endif
    endfunction

    logic [N-1:0]  mem [D];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level_q;
    logic [N-1:0]  cnt, duty;
    logic          pwm_q, strobe_q, under_q;

    logic          full, empty, push, boundary, pop;
    logic [N-1:0]  cnt_next, duty_next;

    assign full     = (level_q == LW'(D));
    assign empty    = (level_q == '0);
    assign push     = in_valid && !full;
    assign boundary = ena && (cnt == {N{1'b1}});
    assign pop      = boundary && !empty;
    assign cnt_next  = cnt + N'(1);
    assign duty_next = pop ? mem[rd_ptr] : duty;

    // Sample storage carries no reset; only the pointers and level define validity.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= to_duty(in_sample);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level_q  <= '0;
            cnt      <= '0;
            duty     <= DUTY_RST;
            pwm_q    <= 1'b0;
            strobe_q <= 1'b0;
            under_q  <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
            strobe_q <= boundary;
            if (boundary && empty)
                under_q <= 1'b1;
            else if (underrun_clr)
                under_q <= 1'b0;
            // Output stage: compare against the count/duty being loaded so pwm_out lines up with cnt.
            if (ena) begin
                cnt   <= cnt_next;
                duty  <= duty_next;
                pwm_q <= (cnt_next < duty_next);
            end
        end
    end

    assign in_ready      = !full;
    assign pwm_out       = pwm_q;
    assign period_strobe = strobe_q;
    assign level         = level_q;
    assign underrun      = under_q;

endmodule

// File: tb/tb_pwm_dac.sv
// Bench for pwm_dac: scenario tasks plus a queue-based model of the sample stream and PWM period.
// Build with PWM_DAC_SIGNED_EN defined to exercise the signed-sample variant.
module tb_pwm_dac;

    localparam int N = 10;
    localparam int D = 4;
    localparam int P = 1 << N;

`ifdef PWM_DAC_SIGNED_EN
    localparam int RST_DUTY = P / 2;
`else
    localparam int RST_DUTY = 0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ena = 1'b0;
    logic [N-1:0] in_sample = '0;
    logic         in_valid = 1'b0;
    logic         underrun_clr = 1'b0;
    logic         in_ready, pwm_out, period_strobe, underrun;
    logic [2:0]   level;
    logic [6:0]   dut_vec;

    int checks = 0;
    int errors = 0;
    int g_mism = 0;
    logic [6:0] g_got, g_exp;

    int  m_cnt, m_duty;
    bit  m_under, m_strobe, m_pwm;
    int  q[$];

    always #5 clk = ~clk;

    pwm_dac #(.N(N), .D(D)) dut (
        .clk(clk), .rst(rst), .ena(ena), .in_sample(in_sample), .in_valid(in_valid),
        .in_ready(in_ready), .underrun_clr(underrun_clr), .pwm_out(pwm_out),
        .period_strobe(period_strobe), .level(level), .underrun(underrun)
    );

    assign dut_vec = {pwm_out, period_strobe, level, underrun, in_ready};

    function automatic int dec(input logic [N-1:0] b);
`ifdef PWM_DAC_SIGNED_EN
        return int'($signed(b)) + P / 2;
`else
        return int'(b);
`endif
    endfunction

    function automatic logic [N-1:0] enc(input int d);
`ifdef PWM_DAC_SIGNED_EN
        return N'(d - P / 2);
`else
        return N'(d);
`endif
    endfunction

    function automatic void model_reset();
        m_cnt = 0; m_duty = RST_DUTY; q.delete();
        m_under = 0; m_strobe = 0; m_pwm = 0;
    endfunction

    function automatic void model_step();
        bit full, empty, bnd;
        full  = (q.size() == D);
        empty = (q.size() == 0);
        bnd   = ena && (m_cnt == P - 1);
        if (bnd && !empty) m_duty = q.pop_front();
        if (bnd && empty) m_under = 1;
        else if (underrun_clr) m_under = 0;
        if (in_valid && !full) q.push_back(dec(in_sample));
        m_strobe = bnd;
        if (ena) begin
            m_cnt = (m_cnt + 1) % P;
            m_pwm = (m_cnt < m_duty);
        end
    endfunction

    function automatic logic [6:0] exp_vec();
        return {m_pwm, m_strobe, 3'(q.size()), m_under, (q.size() < D)};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        if (dut_vec !== exp_vec()) begin
            if (g_mism == 0) begin g_got = dut_vec; g_exp = exp_vec(); end
            g_mism++;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst = 1'b0; ena = 1'b1; in_valid = 1'b0; underrun_clr = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        g_mism = 0;
    endtask

    task automatic push_raw(input logic [N-1:0] b);
        in_sample = b; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic seek_boundary();
        for (int i = 0; i < 2 * P + 100 && m_cnt != P - 1; i++) tick();
    endtask

    task automatic measure_period(output int highs, output int strobes, output int first_low);
        highs = 0; strobes = 0; first_low = P;
        for (int i = 0; i < P; i++) begin
            tick();
            if (pwm_out) highs++;
            else if (first_low == P) first_low = i;
            if (period_strobe) strobes++;
        end
    endtask

    task automatic test_reset();
        int strobe_at;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (dut_vec !== 7'b0000001) begin
            errors++; $display("FAIL reset_initial got %b want %b", dut_vec, 7'b0000001);
        end
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1; ena = 1'b1;
        push_raw(enc(400));
        push_raw(enc(600));
        repeat (298) tick();
        checks++;
        if (level !== 3'd2) begin
            errors++; $display("FAIL reset_pre_level got %0d want 2", level);
        end
        #2 rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_vec !== 7'b0000001) begin
            errors++; $display("FAIL reset_async got %b want %b", dut_vec, 7'b0000001);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        g_mism = 0;
        strobe_at = 0;
        for (int i = 1; i <= P; i++) begin
            tick();
            if (period_strobe && strobe_at == 0) strobe_at = i;
        end
        checks++;
        if (strobe_at !== P) begin
            errors++; $display("FAIL reset_cnt_restart first strobe at %0d want %0d", strobe_at, P);
        end
        checks++;
        if (underrun !== 1'b1) begin
            errors++; $display("FAIL reset_underrun got %b want 1", underrun);
        end
        checks++;
        if (g_mism !== 0) begin
            errors++; $display("FAIL reset_model %0d cycles, first got %b want %b", g_mism, g_got, g_exp);
        end
    endtask

    task automatic test_duty();
        int h, s, fl;
        do_reset();
        push_raw(enc(256));
        seek_boundary();
        for (int k = 0; k < 2; k++) begin
            measure_period(h, s, fl);
            checks++;
            if (h !== 256 || s !== 1 || fl !== 256) begin
                errors++; $display("FAIL duty_period%0d highs %0d strobes %0d first_low %0d want 256 1 256", k, h, s, fl);
            end
        end
        checks++;
        if (g_mism !== 0) begin
            errors++; $display("FAIL duty_model %0d cycles, first got %b want %b", g_mism, g_got, g_exp);
        end
    endtask

    task automatic test_extremes();
        int h, s, fl;
        do_reset();
        push_raw(enc(0));
        push_raw(enc(P - 1));
        seek_boundary();
        measure_period(h, s, fl);
        checks++;
        if (h !== 0 || fl !== 0) begin
            errors++; $display("FAIL extreme_zero highs %0d first_low %0d want 0 0", h, fl);
        end
        measure_period(h, s, fl);
        checks++;
        if (h !== P - 1 || fl !== P - 1) begin
            errors++; $display("FAIL extreme_full highs %0d first_low %0d want %0d %0d", h, fl, P - 1, P - 1);
        end
        checks++;
        if (g_mism !== 0) begin
            errors++; $display("FAIL extreme_model %0d cycles, first got %b want %b", g_mism, g_got, g_exp);
        end
    endtask

    task automatic test_back_to_back();
        int vals[5] = '{10, 20, 30, 40, 50};
        int idx = 0, h = 0, acc_tick = 0, s, fl;
        bit rdy;
        do_reset();
        in_valid = 1'b1;
        for (int t = 1; t <= 3 * P && idx < 5; t++) begin
            in_sample = enc(vals[idx]);
            rdy = in_ready;
            tick();
            if (t >= P) h += int'(pwm_out);
            if (rdy) begin
                idx++;
                if (idx == 4) begin
                    checks++;
                    if ({level, in_ready} !== {3'd4, 1'b0}) begin
                        errors++; $display("FAIL bp_full level %0d ready %b want 4 0", level, in_ready);
                    end
                end
                if (idx == 5) acc_tick = t;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (acc_tick !== P + 1) begin
            errors++; $display("FAIL bp_accept_tick got %0d want %0d", acc_tick, P + 1);
        end
        for (int i = 0; i < P && m_cnt != P - 1; i++) begin
            tick();
            h += int'(pwm_out);
        end
        checks++;
        if (h !== 10) begin
            errors++; $display("FAIL bp_duty0 highs %0d want 10", h);
        end
        for (int k = 1; k < 5; k++) begin
            measure_period(h, s, fl);
            checks++;
            if (h !== vals[k]) begin
                errors++; $display("FAIL bp_duty%0d highs %0d want %0d", k, h, vals[k]);
            end
        end
        checks++;
        if (g_mism !== 0) begin
            errors++; $display("FAIL bp_model %0d cycles, first got %b want %b", g_mism, g_got, g_exp);
        end
    endtask

    task automatic test_underrun();
        int h, s, fl;
        do_reset();
        push_raw(enc(100));
        seek_boundary();
        measure_period(h, s, fl);
        checks++;
        if (h !== 100 || underrun !== 1'b0) begin
            errors++; $display("FAIL ur_first highs %0d underrun %b want 100 0", h, underrun);
        end
        measure_period(h, s, fl);
        checks++;
        if (h !== 100 || underrun !== 1'b1) begin
            errors++; $display("FAIL ur_second highs %0d underrun %b want 100 1", h, underrun);
        end
        measure_period(h, s, fl);
        checks++;
        if (h !== 100) begin
            errors++; $display("FAIL ur_third highs %0d want 100", h);
        end
        underrun_clr = 1'b1;
        tick();
        checks++;
        if (underrun !== 1'b1) begin
            errors++; $display("FAIL ur_set_wins got %b want 1", underrun);
        end
        tick();
        underrun_clr = 1'b0;
        checks++;
        if (underrun !== 1'b0) begin
            errors++; $display("FAIL ur_clear got %b want 0", underrun);
        end
        seek_boundary();
        push_raw(enc(700));
        checks++;
        if ({underrun, level} !== {1'b1, 3'd1}) begin
            errors++; $display("FAIL ur_push_on_boundary underrun %b level %0d want 1 1", underrun, level);
        end
        h = int'(pwm_out);
        for (int i = 0; i < P && m_cnt != P - 1; i++) begin
            tick();
            h += int'(pwm_out);
        end
        checks++;
        if (h !== 100) begin
            errors++; $display("FAIL ur_held_duty highs %0d want 100", h);
        end
        measure_period(h, s, fl);
        checks++;
        if (h !== 700) begin
            errors++; $display("FAIL ur_late_sample highs %0d want 700", h);
        end
        checks++;
        if (g_mism !== 0) begin
            errors++; $display("FAIL ur_model %0d cycles, first got %b want %b", g_mism, g_got, g_exp);
        end
    endtask

    task automatic test_ena_gating();
        int h = 0, nstrobe = 0, last_strobe = -1;
        do_reset();
        push_raw(enc(300));
        seek_boundary();
        for (int i = 0; i <= P + 50; i++) begin
            ena = !(i >= 100 && i < 150);
            in_valid = (i == 120);
            in_sample = enc(5);
            tick();
            if (i == 120) begin
                checks++;
                if (level !== 3'd1) begin
                    errors++; $display("FAIL ena_push_while_frozen level %0d want 1", level);
                end
            end
            if (i < P + 50) h += int'(pwm_out);
            if (period_strobe) begin nstrobe++; last_strobe = i; end
        end
        ena = 1'b1; in_valid = 1'b0;
        checks++;
        if (nstrobe !== 2 || last_strobe !== P + 50) begin
            errors++; $display("FAIL ena_stretch strobes %0d last %0d want 2 %0d", nstrobe, last_strobe, P + 50);
        end
        checks++;
        if (h !== 350) begin
            errors++; $display("FAIL ena_freeze highs %0d want 350", h);
        end
        checks++;
        if (g_mism !== 0) begin
            errors++; $display("FAIL ena_model %0d cycles, first got %b want %b", g_mism, g_got, g_exp);
        end
    endtask

`ifdef PWM_DAC_SIGNED_EN
    task automatic test_signed();
        int h, s, fl;
        int want[3] = '{512, 0, 1023};
        do_reset();
        seek_boundary();
        measure_period(h, s, fl);
        checks++;
        if (h !== 512) begin
            errors++; $display("FAIL signed_idle highs %0d want 512", h);
        end
        push_raw(10'h000);
        push_raw(10'h200);
        push_raw(10'h1FF);
        seek_boundary();
        for (int k = 0; k < 3; k++) begin
            measure_period(h, s, fl);
            checks++;
            if (h !== want[k]) begin
                errors++; $display("FAIL signed_duty%0d highs %0d want %0d", k, h, want[k]);
            end
        end
        checks++;
        if (g_mism !== 0) begin
            errors++; $display("FAIL signed_model %0d cycles, first got %b want %b", g_mism, g_got, g_exp);
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 8 * P; i++) begin
            ena          = ($urandom_range(0, 9) != 0);
            in_valid     = ($urandom_range(0, 499) == 0);
            in_sample    = N'($urandom);
            underrun_clr = ($urandom_range(0, 63) == 0);
            tick();
        end
        ena = 1'b1; in_valid = 1'b0; underrun_clr = 1'b0;
        checks++;
        if (g_mism !== 0) begin
            errors++; $display("FAIL random_model %0d cycles, first got %b want %b", g_mism, g_got, g_exp);
        end
    endtask

    initial begin
        test_reset();
        test_duty();
        test_extremes();
        test_back_to_back();
        test_underrun();
        test_ena_gating();
`ifdef PWM_DAC_SIGNED_EN
        test_signed();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
